// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction-time game core.
// The delay width is sized for the largest random delay the LFSR value can produce.
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StGo,
    StDone,
    StEarly
  } state_e;

  localparam int unsigned RandW         = 7;
  localparam int unsigned DefMinDelayMs = 1000;
  localparam int unsigned DefStepMs     = 16;

  function automatic int unsigned delay_width(input int unsigned min_ms,
                                              input int unsigned step_ms);
    return $clog2(min_ms + ((1 << RandW) - 1) * step_ms + 1);
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the system clock down to a one-cycle millisecond tick.
// restart zeroes the count so the next tick lands a full period later.
module ms_prescaler #(
  parameter int unsigned CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_MS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game: starts a round on the LFSR freeze edge, waits a random delay,
// lights GO and measures the button response in milliseconds.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS  = 50000,
  parameter int unsigned MIN_DELAY_MS = DefMinDelayMs,
  parameter int unsigned STEP_MS      = DefStepMs,
  parameter int unsigned RW           = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cenable,
  input  logic [RandW-1:0] rand_val,
  input  logic             button,
  input  logic             clear,
  output logic             led_go,
  output logic [RW-1:0]    result_ms,
  output logic             result_valid,
  output logic             too_early,
  output logic             busy
);

  localparam int unsigned DelayW = delay_width(MIN_DELAY_MS, STEP_MS);
  localparam logic [RW-1:0] ReactMax = {RW{1'b1}};

  state_e            state_d, state_q;
  logic              cen_d_q;
  logic [2:0]        btn_sync_d, btn_sync_q;
  logic [DelayW-1:0] delay_d, delay_q, new_delay;
  logic [RW-1:0]     react_d, react_q;
  logic [RW-1:0]     result_d, result_q;
  logic              result_valid_d, result_valid_q;
  logic              led_go_q, too_early_q, busy_q;
  logic              cen_rise, btn_rise, tick, restart;

  // btn_sync_q[0..1] is the synchronizer, [2] is the edge-detect delay.
  assign btn_sync_d = {btn_sync_q[1:0], button};
  assign btn_rise   = btn_sync_q[1] & ~btn_sync_q[2];
  assign cen_rise   = cenable & ~cen_d_q;
  assign new_delay  = DelayW'(MIN_DELAY_MS) + DelayW'(rand_val) * DelayW'(STEP_MS);

  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    react_d        = react_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone, StEarly: begin
          if (cen_rise) begin
            state_d = StWait;
            delay_d = new_delay;
          end
        end
        StWait: begin
          if (btn_rise) begin
            state_d = StEarly;
          end else if (tick) begin
            if (delay_q <= DelayW'(1)) begin
              state_d = StGo;
              react_d = '0;
            end else begin
              delay_d = delay_q - 1'b1;
            end
          end
        end
        StGo: begin
          // A tick while already saturated is the timeout; the value reported is the same.
          if (btn_rise || (tick && react_q == ReactMax)) begin
            state_d        = StDone;
            result_d       = react_q;
            result_valid_d = 1'b1;
          end else if (tick) begin
            react_d = react_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign restart = (state_d != state_q) && ((state_d == StWait) || (state_d == StGo));

  ms_prescaler #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cen_d_q        <= 1'b0;
      btn_sync_q     <= '0;
      delay_q        <= '0;
      react_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      led_go_q       <= 1'b0;
      too_early_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cen_d_q        <= cenable;
      btn_sync_q     <= btn_sync_d;
      delay_q        <= delay_d;
      react_q        <= react_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      led_go_q       <= (state_d == StGo);
      too_early_q    <= (state_d == StEarly);
      busy_q         <= (state_d == StWait) || (state_d == StGo);
    end
  end

  assign led_go       = led_go_q;
  assign result_ms    = result_q;
  assign result_valid = result_valid_q;
  assign too_early    = too_early_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Randomized bench for reaction_timer_core against a cycle-count reference model
// that derives GO and result times directly from the round's start cycle.
module tb_reaction_timer_core;

  localparam int C    = 4;
  localparam int MIN  = 2;
  localparam int STEP = 1;
  localparam int RW   = 6;
  localparam int RMAX = (1 << RW) - 1;

  localparam int PIdle  = 0;
  localparam int PWait  = 1;
  localparam int PGo    = 2;
  localparam int PDone  = 3;
  localparam int PEarly = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cenable;
  logic [6:0]    rand_val;
  logic          button;
  logic          clear;
  logic          led_go;
  logic [RW-1:0] result_ms;
  logic          result_valid;
  logic          too_early;
  logic          busy;

  always #5 clk = ~clk;

  reaction_timer_core #(
    .CLKS_PER_MS (C),
    .MIN_DELAY_MS(MIN),
    .STEP_MS     (STEP),
    .RW          (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cenable     (cenable),
    .rand_val    (rand_val),
    .button      (button),
    .clear       (clear),
    .led_go      (led_go),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .too_early   (too_early),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase plus the edge numbers at which WAIT / GO began.
  int m_phase, m_edge, m_wait_start, m_delay, m_go_start, m_result;
  bit m_valid, m_b1, m_b2, m_b3, m_cen_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase    = PIdle;
    m_result   = 0;
    m_valid    = 1'b0;
    m_b1       = 1'b0;
    m_b2       = 1'b0;
    m_b3       = 1'b0;
    m_cen_prev = 1'b0;
  endtask

  // Applies the inputs present at the coming rising edge.
  task automatic model_edge();
    bit rise, crise;
    int el;
    m_edge++;
    rise       = m_b2 & ~m_b3;
    m_b3       = m_b2;
    m_b2       = m_b1;
    m_b1       = button;
    crise      = cenable & ~m_cen_prev;
    m_cen_prev = cenable;
    m_valid    = 1'b0;
    if (clear) begin
      m_phase = PIdle;
    end else if (m_phase == PIdle || m_phase == PDone || m_phase == PEarly) begin
      if (crise) begin
        m_phase      = PWait;
        m_wait_start = m_edge;
        m_delay      = MIN + int'(rand_val) * STEP;
      end
    end else if (m_phase == PWait) begin
      if (rise) m_phase = PEarly;
      else if (m_edge - m_wait_start == m_delay * C) begin
        m_phase    = PGo;
        m_go_start = m_edge;
      end
    end else if (m_phase == PGo) begin
      el = m_edge - m_go_start;
      if (rise || el == (RMAX + 1) * C) begin
        m_phase  = PDone;
        m_result = ((el - 1) / C > RMAX) ? RMAX : (el - 1) / C;
        m_valid  = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("led_go", led_go, m_phase == PGo);
    check_eq("busy", busy, m_phase == PWait || m_phase == PGo);
    check_eq("too_early", too_early, m_phase == PEarly);
    check_eq("result_valid", result_valid, m_valid);
    check_eq("result_ms", result_ms, m_result);
  endtask

  task automatic step();
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      rand_val = 7'($urandom_range(0, 127));
      step();
    end
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    cenable  = 1'b0;
    rand_val = '0;
    button   = 1'b0;
    clear    = 1'b0;
    m_edge   = 0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(20);

    // Round with rand_val=3: GO exactly (2+3)*4 cycles after capture.
    cenable  = 1'b1;
    rand_val = 7'd3;
    step();
    check_eq("busy_after_capture", busy, 1);
    run(19);
    check_eq("go_before_20", led_go, 0);
    run(1);
    check_eq("go_at_20", led_go, 1);
    run(27);
    button = 1'b1;
    run(3);
    check_eq("react_result", result_ms, 7);
    check_eq("react_pulse", result_valid, 1);
    check_eq("react_led_off", led_go, 0);
    run(1);
    check_eq("react_pulse_end", result_valid, 0);
    button = 1'b0;
    run(5);

    // False start during WAIT.
    cenable = 1'b0;
    run(1);
    cenable = 1'b1;
    run(2);
    button = 1'b1;
    run(4);
    check_eq("early_flag", too_early, 1);
    button = 1'b0;
    run(30);
    check_eq("early_held", too_early, 1);
    check_eq("early_no_go", led_go, 0);
    cenable = 1'b0;
    run(1);
    cenable = 1'b1;
    run(1);
    check_eq("early_cleared", too_early, 0);

    // Timeout with cenable toggles mid-WAIT.
    for (int i = 0; i < 2; i++) begin
      cenable = 1'b0;
      run(1);
      cenable = 1'b1;
      run(1);
    end
    k = 0;
    while (result_valid !== 1'b1 && k < 2000) begin
      run(1);
      k++;
    end
    check_eq("timeout_pulse", result_valid, 1);
    check_eq("timeout_value", result_ms, RMAX);
    run(1);
    check_eq("timeout_pulse_end", result_valid, 0);

    // clear in GO, then clear beating a simultaneous cen_rise.
    cenable = 1'b0;
    run(1);
    cenable = 1'b1;
    run(1);
    k = 0;
    while (led_go !== 1'b1 && k < 700) begin
      run(1);
      k++;
    end
    check_eq("clear_go_reached", led_go, 1);
    run(5);
    clear = 1'b1;
    run(1);
    check_eq("clear_led", led_go, 0);
    check_eq("clear_busy", busy, 0);
    check_eq("clear_keeps_result", result_ms, RMAX);
    clear   = 1'b0;
    cenable = 1'b0;
    run(1);
    clear   = 1'b1;
    cenable = 1'b1;
    run(1);
    check_eq("clear_beats_cen", busy, 0);
    clear = 1'b0;
    run(3);

    // Async reset mid-WAIT.
    cenable = 1'b0;
    run(1);
    cenable = 1'b1;
    run(4);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result_ms, 0);
    run(2);
    rst_n = 1'b1;
    run(5);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) cenable = ~cenable;
      if ($urandom_range(0, 30) == 0) button = ~button;
      clear = ($urandom_range(0, 250) == 0);
      run(1);
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Consumer end of the LFSR random-value interface for the reaction-time game.
- Detects the LFSR `cenable` rising edge and captures the 7-bit random value on that edge.
- Waits a random delay derived from that value, then lights the GO LED and measures the player's reaction time in milliseconds.
- Reports the result, or a false start, to the display logic.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per 1 ms tick (bench uses 4).
- MIN_DELAY_MS, 1000, fixed part of the random delay.
- STEP_MS, 16, ms added per unit of captured random value.
- RW, 14, width of the reaction result in ms; saturates at 2^RW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cenable  in  1  LFSR freeze flag; its rising edge starts a round.
- rand_val  in  7  LFSR output; valid whenever cenable=1.
- button  in  1  raw player button, active-high, asynchronous.
- clear  in  1  synchronous return to IDLE, highest priority after reset.
- led_go  out  1  GO lamp, high only in state GO.
- result_ms  out  RW  last measured reaction time in ms.
- result_valid  out  1  one-cycle pulse when result_ms updates.
- too_early  out  1  held high in state EARLY.
- busy  out  1  high in WAIT or GO.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; result_ms=0.
  - Prescaler, counters, sync flops and cenable_d cleared.
- Input conditioning:
  - button passes through a 2-flop synchronizer; btn_rise = s2 & ~s3 (third flop).
  - Raw-to-btn_rise latency is 3 cycles.
  - cen_rise = cenable & ~cenable_d.
- ms tick:
  - Prescaler counts 0..CLKS_PER_MS-1; tick is asserted when it reaches CLKS_PER_MS-1.
  - Prescaler is zeroed on every entry to WAIT or GO, so the first tick falls exactly CLKS_PER_MS cycles after entry.
- IDLE: on cen_rise, load delay_ms = MIN_DELAY_MS + rand_val*STEP_MS (unsigned, width wide enough for MIN+127*STEP) -> WAIT.
- WAIT:
  - Decrement delay_ms on each tick; when a tick arrives with delay_ms==1 -> GO.
  - WAIT lasts exactly delay_ms*CLKS_PER_MS cycles.
  - btn_rise in WAIT -> EARLY; this takes priority over a same-cycle tick transition.
- GO:
  - led_go=1; react_cnt=0 on entry; react_cnt increments per tick, saturating at 2^RW-1.
  - On btn_rise -> DONE: result_ms <= react_cnt (ticks completed before the detect cycle); result_valid=1 for that one cycle.
  - If react_cnt saturated and a further tick arrives -> DONE with result_ms=2^RW-1 (timeout).
  - If btn_rise and that timeout tick coincide, btn_rise wins; the value is the same.
- DONE: hold result_ms; on cen_rise, start a new round exactly as from IDLE.
- EARLY: too_early=1, result_ms unchanged; on cen_rise, start a new round.
- cen_rise in WAIT or GO is ignored; no restart mid-round.
- clear=1 in any state -> IDLE next cycle:
  - too_early and led_go drop; result_ms is retained.
  - Beats a simultaneous cen_rise.
- Reset mid-round returns immediately to the reset state; no result_valid pulse.
- busy = (state==WAIT)|(state==GO), registered with the state.

Decomposition:
- Package reaction_pkg:
  - state enum {IDLE, WAIT, GO, DONE, EARLY}.
  - Delay-width localparam computed from MIN_DELAY_MS/STEP_MS.
- Sub-module ms_prescaler:
  - Inputs clk, rst_n, restart; output tick.
  - Instantiated once.

Test Plan (CLKS_PER_MS=4, MIN_DELAY_MS=2, STEP_MS=1, RW=6):
- Reset then idle 20 cycles -> all outputs 0, state IDLE, no result_valid.
- cenable 0->1 with rand_val=3 -> busy next cycle; led_go rises exactly 20 cycles after capture ((2+3)*4); rand_val changes after capture have no effect.
- GO active, button pulsed so btn_rise lands after 7 ticks -> result_ms=7, result_valid high exactly one cycle, led_go falls the same cycle, busy=0.
- Button pressed during WAIT -> too_early=1 held, led_go never rises; cenable re-rise starts a fresh round, clearing too_early.
- No button in GO for 64 ticks -> result_ms=63, result_valid one pulse; extra cenable toggles mid-WAIT are ignored.
- clear asserted in GO, and rst_n pulsed low mid-WAIT -> IDLE next cycle / immediately, led_go=0, no result_valid; result_ms kept after clear, zeroed after reset.
